ds_tx_sched: RTL and testbench

Transmit-side scheduler for one IEEE 1355 DS link in the node. Shares the link character encoder between REQ_N packet sources (switch/button data generators) and the local receiver's flow-control needs. Enforces credit-based flow control: each received FCT grants 8 N-chars. Issues FCTs at top priority, arbitrates round-robin at packet boundaries, and fills idle slots with NULL to keep the link alive.

---
 rtl/ds_pkg.sv | 24 ++
 rtl/ds_rr_arb.sv | 39 +++
 rtl/ds_tx_sched.sv | 183 ++++++++++++++++++
 tb/tb_ds_tx_sched.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared DS link character codes and tx credit constants
package ds_pkg;

  // Character type codes shared by the scheduler, encoder and decoder.
  typedef enum logic [1:0] {
    CH_NULL = 2'b00,
    CH_FCT  = 2'b01,
    CH_DATA = 2'b10,
    CH_EOP  = 2'b11
  } ds_char_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } sched_state_e;

  localparam int CREDIT_STEP = 8;   // N-chars granted per received FCT
  localparam int CREDIT_MAX  = 56;  // saturation point of the credit counter
  localparam int CREDIT_W    = 6;
  localparam int FCT_PEND_W  = 3;
  localparam int CHAR_W      = 9;   // requester char: EOP flag + data byte
  localparam int EOP_BIT     = 8;

endpackage

// File: rtl/ds_rr_arb.sv
// rtl/ds_rr_arb.sv - round-robin pick of the first requester after last_owner
//   req        : request vector
//   last_owner : index of the requester that finished the previous packet
//   pick       : one-hot winner (0 when no request)
//   pick_idx   : winner index (0 when no request)
//   any        : at least one request present
module ds_rr_arb
  import ds_pkg::*;
#(
  parameter int REQ_N = 2,
  parameter int IW    = $clog2(REQ_N)
) (
  input  logic [REQ_N-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [REQ_N-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any
);

  logic [IW:0] cand;

  // Walk the ring starting one past last_owner; last_owner itself is
  // visited last so it only wins when nobody else is asking.
  always_comb begin
    any      = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= REQ_N; i++) begin
      cand = {1'b0, last_owner} + (IW+1)'(i);
      if (cand >= (IW+1)'(REQ_N)) cand = cand - (IW+1)'(REQ_N);
      if (!any && req[cand[IW-1:0]]) begin
        any      = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
    pick = any ? (REQ_N'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/ds_tx_sched.sv
// rtl/ds_tx_sched.sv - DS link transmit scheduler: FCT priority, credit, packet round-robin
//   clk, rst_n         : clock, async active-low reset
//   link_en            : link running; low flushes scheduler state
//   req, req_char      : per-requester valid + {EOP flag, data byte}
//   req_ack            : pulse, requester char loaded this cycle
//   fct_req, fct_rcvd  : send one FCT / far end granted CREDIT_STEP chars
//   tx_valid/type/data : output character register, tx_ready handshake
//   grant              : one-hot packet owner
//   credit, credit_err : tx credit and sticky overflow flag
module ds_tx_sched
  import ds_pkg::*;
#(
  parameter int REQ_N = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    link_en,
  input  logic [REQ_N-1:0]        req,
  input  logic [CHAR_W*REQ_N-1:0] req_char,
  output logic [REQ_N-1:0]        req_ack,
  input  logic                    fct_req,
  input  logic                    fct_rcvd,
  output logic                    tx_valid,
  output logic [1:0]              tx_type,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic [REQ_N-1:0]        grant,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    credit_err
);

  localparam int IW = $clog2(REQ_N);

  sched_state_e          state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         last_q, last_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  credit_err_q, credit_err_d;
  logic [FCT_PEND_W-1:0] pend_q, pend_d;
  logic                  tx_valid_q, tx_valid_d;
  ds_char_e              tx_type_q, tx_type_d;
  logic [7:0]            tx_data_q, tx_data_d;

  logic [CHAR_W-1:0]     chars [REQ_N];
  logic [REQ_N-1:0]      arb_pick;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;

  logic                  load;
  logic                  use_fct;
  logic                  data_ok;
  logic                  take_char;
  logic [IW-1:0]         sel_idx;
  logic [CHAR_W-1:0]     sel_char;
  logic [REQ_N-1:0]      ack_vec;
  logic [CREDIT_W:0]     credit_sum;

  for (genvar g = 0; g < REQ_N; g++) begin : g_unpack
    assign chars[g] = req_char[g*CHAR_W +: CHAR_W];
  end

  ds_rr_arb #(.REQ_N(REQ_N), .IW(IW)) u_arb (
    .req        (req),
    .last_owner (last_q),
    .pick       (arb_pick),
    .pick_idx   (arb_idx),
    .any        (arb_any)
  );

  // Slot selection: FCT beats data; inside a packet only the owner may
  // send, otherwise the round-robin winner opens (or empties) a packet.
  always_comb begin
    load      = link_en & (~tx_valid_q | tx_ready);
    use_fct   = (pend_q != '0);
    sel_idx   = (state_q == ST_PKT) ? owner_q : arb_idx;
    sel_char  = chars[sel_idx];
    data_ok   = (credit_q != '0) && ((state_q == ST_PKT) ? req[owner_q] : arb_any);
    take_char = load && !use_fct && data_ok;
    ack_vec   = (state_q == ST_PKT) ? (REQ_N'(1) << owner_q) : arb_pick;
    req_ack   = take_char ? ack_vec : '0;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    pend_d       = pend_q;
    tx_valid_d   = tx_valid_q;
    tx_type_d    = tx_type_q;
    tx_data_d    = tx_data_q;
    credit_sum   = '0;

    if (!link_en) begin
      // Flush; last_owner and the sticky error survive so fairness and
      // diagnostics carry across a link restart.
      state_d    = ST_IDLE;
      credit_d   = '0;
      pend_d     = '0;
      tx_valid_d = 1'b0;
      tx_type_d  = CH_NULL;
      tx_data_d  = '0;
    end else begin
      if (load) begin
        tx_valid_d = 1'b1;
        tx_data_d  = '0;
        if (use_fct) begin
          tx_type_d = CH_FCT;
        end else if (data_ok) begin
          if (sel_char[EOP_BIT]) begin
            tx_type_d = CH_EOP;
          end else begin
            tx_type_d = CH_DATA;
            tx_data_d = sel_char[7:0];
          end
        end else begin
          tx_type_d = CH_NULL;
        end
      end

      if (take_char) begin
        if (sel_char[EOP_BIT]) begin
          state_d = ST_IDLE;
          last_d  = sel_idx;
        end else begin
          state_d = ST_PKT;
          owner_d = sel_idx;
        end
      end

      // Request and FCT send in the same cycle cancel out.
      if (fct_req && !(load && use_fct)) begin
        if (pend_q != '1) pend_d = pend_q + 1'b1;
      end else if (!fct_req && load && use_fct) begin
        pend_d = pend_q - 1'b1;
      end

      // Wide sum so a grant on top of a near-full counter is still visible.
      credit_sum = {1'b0, credit_q}
                 + (fct_rcvd  ? (CREDIT_W+1)'(CREDIT_STEP) : '0)
                 - (take_char ? (CREDIT_W+1)'(1) : '0);
      if (credit_sum > (CREDIT_W+1)'(CREDIT_MAX)) begin
        credit_d     = CREDIT_W'(CREDIT_MAX);
        credit_err_d = 1'b1;
      end else begin
        credit_d = credit_sum[CREDIT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_q       <= IW'(REQ_N-1);
      credit_q     <= '0;
      credit_err_q <= 1'b0;
      pend_q       <= '0;
      tx_valid_q   <= 1'b0;
      tx_type_q    <= CH_NULL;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      pend_q       <= pend_d;
      tx_valid_q   <= tx_valid_d;
      tx_type_q    <= tx_type_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_type    = tx_type_q;
  assign tx_data    = tx_data_q;
  assign credit     = credit_q;
  assign credit_err = credit_err_q;
  assign grant      = (state_q == ST_PKT) ? (REQ_N'(1) << owner_q) : '0;

endmodule

// File: tb/tb_ds_tx_sched.sv
// tb/tb_ds_tx_sched.sv - randomized bench for ds_tx_sched against a packet-level model
module tb_ds_tx_sched;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           link_en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [9*N-1:0] req_char = '0;
  logic [N-1:0]   req_ack;
  logic           fct_req = 1'b0;
  logic           fct_rcvd = 1'b0;
  logic           tx_valid;
  logic [1:0]     tx_type;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b0;
  logic [N-1:0]   grant;
  logic [5:0]     credit;
  logic           credit_err;

  always #5 clk = ~clk;

  ds_tx_sched #(.REQ_N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link_en    (link_en),
    .req        (req),
    .req_char   (req_char),
    .req_ack    (req_ack),
    .fct_req    (fct_req),
    .fct_rcvd   (fct_rcvd),
    .tx_valid   (tx_valid),
    .tx_type    (tx_type),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .credit     (credit),
    .credit_err (credit_err)
  );

  // Pending packet characters per requester; front is what req_char shows.
  logic [8:0] q [N][$];

  // Reference model state, in spec terms (type codes 0 NULL,1 FCT,2 DATA,3 EOP).
  int m_valid, m_type, m_data, m_credit, m_err, m_pend;
  int m_inpkt, m_owner, m_last;
  int n_pass = 0;
  int n_checks = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_packet(input int k);
    int len;
    len = $urandom_range(0, 4);
    for (int i = 0; i < len; i++) q[k].push_back({1'b0, 8'($urandom_range(0, 255))});
    q[k].push_back({1'b1, 8'($urandom_range(0, 255))});
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      req[k] = (q[k].size() > 0);
      req_char[k*9 +: 9] = (q[k].size() > 0) ? q[k][0] : 9'd0;
    end
  endtask

  int fc_pct [4] = '{4, 6, 6, 40};
  int fr_pct [4] = '{5, 10, 10, 10};

  initial begin
    int ld, ck, ct, exp_ack, kk;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", int'(tx_valid), 0);
    check_eq("rst_tx_type", int'(tx_type), 0);
    check_eq("rst_tx_data", int'(tx_data), 0);
    check_eq("rst_grant", int'(grant), 0);
    check_eq("rst_credit", int'(credit), 0);
    check_eq("rst_credit_err", int'(credit_err), 0);
    check_eq("rst_req_ack", int'(req_ack), 0);

    m_valid = 0; m_type = 0; m_data = 0; m_credit = 0; m_err = 0; m_pend = 0;
    m_inpkt = 0; m_owner = 0; m_last = N - 1;

    @(negedge clk);
    rst_n = 1'b1;

    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        for (int k = 0; k < N; k++)
          if (q[k].size() == 0 && $urandom_range(0, 3) == 0) push_packet(k);
        link_en  = (ph == 2) ? ($urandom_range(0, 19) != 0) : 1'b1;
        tx_ready = (ph == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        fct_rcvd = ($urandom_range(0, 99) < fc_pct[ph]);
        fct_req  = ($urandom_range(0, 99) < fr_pct[ph]);
        drive_reqs();
        #1;

        // What the model would put in the slot at the coming edge.
        ld = (link_en && (!m_valid || tx_ready)) ? 1 : 0;
        ck = -1;
        ct = 0;
        if (m_pend > 0) begin
          ct = 1;
        end else if (m_credit > 0) begin
          if (m_inpkt != 0) begin
            if (q[m_owner].size() > 0) ck = m_owner;
          end else begin
            for (int d = 1; d <= N; d++) begin
              kk = (m_last + d) % N;
              if (ck < 0 && q[kk].size() > 0) ck = kk;
            end
          end
        end
        if (ck >= 0) ct = q[ck][0][8] ? 3 : 2;
        exp_ack = (ld != 0 && ck >= 0) ? (1 << ck) : 0;

        check_eq("req_ack", int'(req_ack), exp_ack);
        check_eq("tx_valid", int'(tx_valid), m_valid);
        check_eq("tx_type", int'(tx_type), m_type);
        check_eq("tx_data", int'(tx_data), m_data);
        check_eq("credit", int'(credit), m_credit);
        check_eq("credit_err", int'(credit_err), m_err);
        check_eq("grant", int'(grant), (m_inpkt != 0) ? (1 << m_owner) : 0);

        @(posedge clk);
        if (!link_en) begin
          m_valid = 0; m_type = 0; m_data = 0;
          m_inpkt = 0; m_credit = 0; m_pend = 0;
        end else begin
          if (ld != 0) begin
            m_valid = 1;
            m_type  = ct;
            m_data  = (ct == 2) ? int'(q[ck][0][7:0]) : 0;
            if (ct == 1) m_pend--;
            if (ck >= 0) begin
              m_credit--;
              if (ct == 3) begin
                m_inpkt = 0;
                m_last  = ck;
              end else begin
                m_inpkt = 1;
                m_owner = ck;
              end
              void'(q[ck].pop_front());
            end
          end
          if (fct_req && m_pend < 7) m_pend++;
          if (fct_rcvd) m_credit += 8;
          if (m_credit > 56) begin
            m_credit = 56;
            m_err = 1;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
